// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: issues sequential reads to a synchronous ROM
// and buffers {instr, pc} pairs in a credit-managed FIFO with redirect flush.
module prefetch_unit #(
    parameter int XLEN = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           redirect_valid,
    input  logic [XLEN-1:0]                redirect_pc,
    output logic                           mem_en,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic [XLEN-1:0]                mem_rdata,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [XLEN-1:0]                out_instr,
    output logic [XLEN-1:0]                out_pc,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] held_pc;
    logic            inflight;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] instr_q [FIFO_DEPTH];
    logic [XLEN-1:0] pc_q    [FIFO_DEPTH];
    logic [CW:0]     credit;
    logic            issue;
    logic            push;
    logic            pop;
    logic            full;
    logic            unused_lsb;

    // Outstanding read reserves a slot, so the FIFO can never overflow.
    assign credit     = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign issue      = !rst && (credit < (CW+1)'(FIFO_DEPTH));
    assign mem_en     = issue;
    assign mem_addr   = fetch_pc[ADDR_WIDTH+1:2];
    assign out_valid  = (count != '0);
    assign pop        = out_valid && out_ready;
    assign push       = inflight && !redirect_valid;
    assign full       = (count == CW'(FIFO_DEPTH));
    assign out_instr  = instr_q[rd_ptr];
    assign out_pc     = pc_q[rd_ptr];
    assign fifo_count = count;
    assign unused_lsb = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            held_pc  <= '0;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                held_pc  <= fetch_pc;
                fetch_pc <= fetch_pc + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= mem_rdata;
            pc_q[wr_ptr]    <= held_pc;
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: directed scenarios plus random ready/redirect/reset
// traffic, checked against an instruction-stream model of the consumer view.
module tb_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_en;
    logic [4:0]  mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  fifo_count;

    logic [31:0] rom [32];

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_pc = '0;
    int          idle_run = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_instr = '0;
    logic        found;

    prefetch_unit dut (
        .clk(clk),
        .rst(rst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .mem_en(mem_en),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= rom[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Consumer-view model: accepted instructions form a sequential stream
    // restarting at each redirect target or at RESET_PC after reset.
    task automatic sample();
        @(negedge clk);
        if (rst) begin
            check("rst_valid", 32'(out_valid), 0);
            check("rst_mem_en", 32'(mem_en), 0);
            exp_pc = '0;
            idle_run = 0;
            prev_stall = 1'b0;
        end else begin
            check("valid_vs_count", 32'(out_valid), 32'(fifo_count != 0));
            check("count_bound", 32'(fifo_count <= 4), 1);
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 1);
                check("stall_pc", out_pc, prev_pc);
                check("stall_instr", out_instr, prev_instr);
            end
            if (out_valid && out_ready) begin
                check("stream_pc", out_pc, exp_pc);
                check("stream_instr", out_instr, rom[exp_pc[6:2]]);
                exp_pc = exp_pc + 32'd4;
            end
            if (!out_valid) idle_run++;
            else idle_run = 0;
            check("refill_latency", 32'(idle_run > 2), 0);
            prev_stall = out_valid && !out_ready && !redirect_valid;
            prev_pc = out_pc;
            prev_instr = out_instr;
            if (redirect_valid) begin
                exp_pc = {redirect_pc[31:2], 2'b00};
                idle_run = 0;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    initial begin
        for (int k = 0; k < 32; k++) rom[k] = 32'(k);
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset release and streaming.
        sample();
        check("c0_mem_en", 32'(mem_en), 1);
        check("c0_addr", 32'(mem_addr), 0);
        check("c0_valid", 32'(out_valid), 0);
        advance();
        sample();
        check("c1_valid", 32'(out_valid), 0);
        advance();
        for (int c = 2; c < 20; c++) begin
            sample();
            check("thru_valid", 32'(out_valid), 1);
            check("thru_pc", out_pc, 32'((c - 2) * 4));
            check("thru_instr", out_instr, 32'(c - 2));
            advance();
        end

        // Consumer stall fills the buffer.
        out_ready = 1'b0;
        repeat (10) tick();
        sample();
        check("stall_mem_en", 32'(mem_en), 0);
        check("stall_count", 32'(fifo_count), 4);
        advance();

        // Redirect while full.
        redirect_valid = 1'b1;
        redirect_pc = 32'h4E;
        sample();
        check("full_before", 32'(fifo_count), 4);
        advance();
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        sample();
        check("rd_count", 32'(fifo_count), 0);
        check("rd_mem_en", 32'(mem_en), 1);
        check("rd_addr", 32'(mem_addr), 32'h13);
        check("rd_n1_valid", 32'(out_valid), 0);
        advance();
        sample();
        check("rd_n2_valid", 32'(out_valid), 0);
        advance();
        sample();
        check("rd_n3_valid", 32'(out_valid), 1);
        check("rd_n3_pc", out_pc, 32'h4C);
        check("rd_n3_instr", out_instr, 32'h13);
        advance();
        repeat (4) tick();

        // Back-to-back redirects.
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        tick();
        redirect_pc = 32'h20;
        tick();
        redirect_valid = 1'b0;
        sample();
        check("b2b_n2_valid", 32'(out_valid), 0);
        advance();
        sample();
        check("b2b_n3_valid", 32'(out_valid), 0);
        advance();
        sample();
        check("b2b_n4_valid", 32'(out_valid), 1);
        check("b2b_n4_pc", out_pc, 32'h20);
        advance();
        repeat (3) tick();

        // Address wrap through 0x7C.
        redirect_valid = 1'b1;
        redirect_pc = 32'h70;
        tick();
        redirect_valid = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            sample();
            if (i <= 5) begin
                check("wrap_mem_en", 32'(mem_en), 1);
                check("wrap_addr", 32'(mem_addr), 32'((27 + i) % 32));
            end
            if (i == 7) begin
                check("wrap_pc", out_pc, 32'h80);
                check("wrap_instr", out_instr, 32'h0);
            end
            advance();
        end
        repeat (4) tick();

        // Asynchronous reset mid-stream with three entries buffered.
        out_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (fifo_count == 3) begin
                found = 1'b1;
                break;
            end
            advance();
        end
        check("reach_count3", 32'(found), 1);
        rst = 1'b1;
        #1;
        check("async_valid", 32'(out_valid), 0);
        check("async_mem_en", 32'(mem_en), 0);
        check("async_count", 32'(fifo_count), 0);
        advance();
        repeat (2) tick();
        rst = 1'b0;
        out_ready = 1'b1;
        sample();
        check("rel_mem_en", 32'(mem_en), 1);
        check("rel_addr", 32'(mem_addr), 0);
        advance();
        repeat (6) tick();

        // Random traffic with fresh ROM contents.
        rst = 1'b1;
        for (int k = 0; k < 32; k++) rom[k] = $urandom;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom % 10) < 7;
            redirect_valid = ($urandom % 20) == 0;
            if ($urandom % 3 == 0) redirect_pc = $urandom;
            else redirect_pc = $urandom % 128;
            rst = ($urandom % 64) == 0;
            tick();
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
